// File: rtl/aes_bram_pkg.sv
// Shared definitions for the AES BRAM read responder: FSM state encoding,
// read-latency limits and the width of the successful-read counter.
package aes_bram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } rd_state_t;

  localparam int RD_LATENCY_DEFAULT = 1;
  localparam int RD_LATENCY_MIN     = 1;
  localparam int RD_LATENCY_MAX     = 4;
  localparam int RD_COUNT_WIDTH     = 16;
  localparam int RD_LAT_CNT_WIDTH   = $clog2(RD_LATENCY_MAX + 1);

  // A request is usable only if word aligned and inside the populated BRAM.
  function automatic logic req_addr_ok(input logic [31:0] byte_addr,
                                       input int unsigned depth);
    logic [31:0] word_idx;
    word_idx = {2'b00, byte_addr[31:2]};
    return (byte_addr[1:0] == 2'b00) && (word_idx < depth);
  endfunction

endpackage

// File: rtl/aes_bram_rd_responder.sv
// Single-word BRAM read responder for the AES core. A level request is
// validated, turned into one BRAM enable pulse, the BRAM pipeline latency is
// waited out and the word is returned under a complete/error handshake that
// closes when the requester drops aes_start_read.
module aes_bram_rd_responder
  import aes_bram_pkg::*;
#(
  parameter int ADDR_WIDTH   = 10,
  parameter int DEPTH        = 1024,
  parameter int READ_LATENCY = RD_LATENCY_DEFAULT
) (
  input  logic                      aes_clk,
  input  logic                      aes_rst_n,
  input  logic                      aes_start_read,
  input  logic [31:0]               aes_bram_addr,
  output logic [31:0]               aes_bram_read_data,
  output logic                      bram_complete,
  output logic                      bram_error,
  output logic                      bram_en,
  output logic [ADDR_WIDTH-1:0]     bram_addr,
  input  logic [31:0]               bram_dout,
  output logic                      rd_busy,
  output logic [RD_COUNT_WIDTH-1:0] rd_count
);

  localparam int unsigned                 DEPTH_U  = DEPTH;
  localparam logic [RD_LAT_CNT_WIDTH-1:0] LAT_INIT = RD_LAT_CNT_WIDTH'(READ_LATENCY);

  generate
    if (READ_LATENCY < RD_LATENCY_MIN || READ_LATENCY > RD_LATENCY_MAX) begin : g_bad_latency
      $error("aes_bram_rd_responder: READ_LATENCY outside supported range");
    end
  endgenerate

  rd_state_t                   state_reg, state_next;
  logic                        req_ok_reg;
  logic                        bram_en_reg;
  logic [ADDR_WIDTH-1:0]       bram_addr_reg;
  logic [RD_LAT_CNT_WIDTH-1:0] lat_cnt_reg;
  logic [31:0]                 rdata_reg;
  logic                        complete_reg;
  logic                        error_reg;
  logic                        busy_reg;
  logic [RD_COUNT_WIDTH-1:0]   rd_count_reg;
  logic                        addr_ok;

  assign addr_ok = req_addr_ok(aes_bram_addr, DEPTH_U);

  // Next-state logic; an invalid request passes through ISSUE without an enable.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (aes_start_read) state_next = ST_ISSUE;
      ST_ISSUE: state_next = req_ok_reg ? ST_WAIT : ST_DONE;
      ST_WAIT:  if (lat_cnt_reg == '0) state_next = ST_DONE;
      ST_DONE:  if (!aes_start_read) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // State register with a registered busy flag that tracks the next state.
  always_ff @(posedge aes_clk or negedge aes_rst_n) begin
    if (!aes_rst_n) begin
      state_reg <= ST_IDLE;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      busy_reg  <= (state_next != ST_IDLE);
    end
  end

  // Request latch, single-cycle BRAM enable and the latency down-counter.
  always_ff @(posedge aes_clk or negedge aes_rst_n) begin
    if (!aes_rst_n) begin
      req_ok_reg    <= 1'b0;
      bram_en_reg   <= 1'b0;
      bram_addr_reg <= '0;
      lat_cnt_reg   <= '0;
    end else begin
      bram_en_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (aes_start_read) begin
            req_ok_reg <= addr_ok;
            if (addr_ok) begin
              bram_en_reg   <= 1'b1;
              bram_addr_reg <= aes_bram_addr[ADDR_WIDTH+1:2];
            end
          end
        end
        ST_ISSUE: lat_cnt_reg <= LAT_INIT;
        ST_WAIT:  if (lat_cnt_reg != '0) lat_cnt_reg <= lat_cnt_reg - 1'b1;
        default:  ;
      endcase
    end
  end

  // Response handshake, returned data and the saturating success counter.
  always_ff @(posedge aes_clk or negedge aes_rst_n) begin
    if (!aes_rst_n) begin
      rdata_reg    <= '0;
      complete_reg <= 1'b0;
      error_reg    <= 1'b0;
      rd_count_reg <= '0;
    end else begin
      case (state_reg)
        ST_ISSUE: begin
          if (!req_ok_reg) begin
            rdata_reg    <= '0;
            complete_reg <= 1'b1;
            error_reg    <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (lat_cnt_reg == '0) begin
            rdata_reg    <= bram_dout;
            complete_reg <= 1'b1;
            error_reg    <= 1'b0;
            if (rd_count_reg != '1) rd_count_reg <= rd_count_reg + 1'b1;
          end
        end
        ST_DONE: begin
          // Data is deliberately kept after the handshake closes.
          if (!aes_start_read) begin
            complete_reg <= 1'b0;
            error_reg    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign aes_bram_read_data = rdata_reg;
  assign bram_complete      = complete_reg;
  assign bram_error         = error_reg;
  assign bram_en            = bram_en_reg;
  assign bram_addr          = bram_addr_reg;
  assign rd_busy            = busy_reg;
  assign rd_count           = rd_count_reg;

endmodule

// File: tb/tb_aes_bram_rd_responder.sv
// Directed bench for aes_bram_rd_responder: one instance at latency 1, one at
// latency 4, each with a behavioural BRAM, and a scoreboard of expected words.
module tb_aes_bram_rd_responder;

  logic        clk;
  logic        rst_n;
  logic        start0, start1;
  logic [31:0] req_addr;

  logic [31:0] rdata0, rdata1, dout0, dout1;
  logic        comp0, comp1, err0, err1, en0, en1, busy0, busy1;
  logic [9:0]  baddr0, baddr1;
  logic [15:0] cnt0, cnt1;

  logic [31:0] mem [0:1023];

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;
  exp_t sb[$];

  int n_pass, n_fail, n_total;
  int exp_cnt [2];
  int en_cnt  [2];
  logic [9:0] en_addr [2];

  int          sel;
  logic [31:0] m_rdata;
  logic        m_comp, m_err, m_en, m_busy;
  logic [9:0]  m_baddr;
  logic [15:0] m_cnt;

  aes_bram_rd_responder #(.ADDR_WIDTH(10), .DEPTH(1024), .READ_LATENCY(1)) dut0 (
    .aes_clk(clk), .aes_rst_n(rst_n), .aes_start_read(start0), .aes_bram_addr(req_addr),
    .aes_bram_read_data(rdata0), .bram_complete(comp0), .bram_error(err0), .bram_en(en0),
    .bram_addr(baddr0), .bram_dout(dout0), .rd_busy(busy0), .rd_count(cnt0));

  aes_bram_rd_responder #(.ADDR_WIDTH(10), .DEPTH(1024), .READ_LATENCY(4)) dut1 (
    .aes_clk(clk), .aes_rst_n(rst_n), .aes_start_read(start1), .aes_bram_addr(req_addr),
    .aes_bram_read_data(rdata1), .bram_complete(comp1), .bram_error(err1), .bram_en(en1),
    .bram_addr(baddr1), .bram_dout(dout1), .rd_busy(busy1), .rd_count(cnt1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Latency-1 BRAM: word appears after the edge that samples the enable.
  always @(posedge clk) if (en0 === 1'b1) dout0 <= mem[baddr0];

  // Latency-4 BRAM: three further pipeline stages before the output register.
  logic [2:0]  vld1;
  logic [31:0] dat1 [3];
  always @(posedge clk) begin
    vld1    <= {vld1[1:0], en1 === 1'b1};
    dat1[0] <= mem[baddr1];
    dat1[1] <= dat1[0];
    dat1[2] <= dat1[1];
    if (vld1[2]) dout1 <= dat1[2];
  end
  initial vld1 = 3'b000;

  // Enable pulse monitor.
  always @(posedge clk) begin
    if (en0 === 1'b1) begin en_cnt[0]++; en_addr[0] = baddr0; end
    if (en1 === 1'b1) begin en_cnt[1]++; en_addr[1] = baddr1; end
  end

  always_comb begin
    if (sel == 1) begin
      m_rdata = rdata1; m_comp = comp1; m_err = err1; m_en = en1;
      m_busy = busy1; m_baddr = baddr1; m_cnt = cnt1;
    end else begin
      m_rdata = rdata0; m_comp = comp0; m_err = err0; m_en = en0;
      m_busy = busy0; m_baddr = baddr0; m_cnt = cnt0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, " complete"}, 32'(m_comp), 32'd0);
    check({tag, " error"},    32'(m_err),  32'd0);
    check({tag, " en"},       32'(m_en),   32'd0);
    check({tag, " addr"},     32'(m_baddr), 32'd0);
    check({tag, " data"},     m_rdata,     32'd0);
    check({tag, " busy"},     32'(m_busy), 32'd0);
    check({tag, " count"},    32'(m_cnt),  32'd0);
  endtask

  // One full handshake on instance inst; lat is the edge after which
  // bram_complete must first be seen, edge 0 being the sampling edge.
  task automatic do_read(input int inst, input logic [31:0] a, input int lat,
                         input bit err, input string tag);
    exp_t e;
    int   n;
    int   en_before;
    sel    = inst;
    e.err  = err;
    e.data = err ? 32'd0 : mem[a[11:2]];
    sb.push_back(e);
    if (!err && exp_cnt[inst] != 32'hFFFF) exp_cnt[inst]++;
    en_before = en_cnt[inst];

    @(negedge clk);
    req_addr = a;
    if (inst == 0) start0 = 1'b1; else start1 = 1'b1;
    @(posedge clk); #1;
    req_addr = a ^ 32'h0000_0FF0;   // must be ignored once accepted
    n = 0;
    while (m_comp !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, " latency"}, n, lat);
    e = sb.pop_front();
    check({tag, " data"},  m_rdata, e.data);
    check({tag, " error"}, 32'(m_err), 32'(e.err));
    check({tag, " en_pulses"}, en_cnt[inst] - en_before, err ? 0 : 1);
    if (!err) check({tag, " bram_addr"}, 32'(en_addr[inst]), 32'(a[11:2]));
    check({tag, " count"}, 32'(m_cnt), exp_cnt[inst]);
    check({tag, " busy"},  32'(m_busy), 32'd1);

    // Requester keeps the level one more cycle: response must hold.
    @(posedge clk); #1;
    check({tag, " hold_complete"}, 32'(m_comp), 32'd1);
    check({tag, " hold_data"}, m_rdata, e.data);

    @(negedge clk);
    if (inst == 0) start0 = 1'b0; else start1 = 1'b0;
    @(posedge clk); #1;
    check({tag, " close_complete"}, 32'(m_comp), 32'd0);
    check({tag, " close_error"},    32'(m_err),  32'd0);
    check({tag, " close_data"},     m_rdata, e.data);
    check({tag, " close_busy"},     32'(m_busy), 32'd0);
  endtask

  initial begin
    n_pass = 0; n_fail = 0; n_total = 0;
    exp_cnt[0] = 0; exp_cnt[1] = 0;
    en_cnt[0] = 0;  en_cnt[1] = 0;
    en_addr[0] = '0; en_addr[1] = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h5A00_0001 + i * 32'h0001_0101;
    mem[4] = 32'hDEADBEEF;
    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; req_addr = '0; sel = 0;

    repeat (2) @(posedge clk);
    #1;
    sel = 0; #1; check_zero("reset0");
    sel = 1; #1; check_zero("reset1");
    @(negedge clk); rst_n = 1'b1;

    // Basic latency-1 read of word 4.
    do_read(0, 32'h0000_0010, 3, 1'b0, "lat1_w4");

    // Misaligned and out-of-range requests.
    do_read(0, 32'h0000_0013, 1, 1'b1, "misaligned");
    do_read(0, 32'h0000_1000, 1, 1'b1, "out_of_range");

    // Twelve back-to-back reads, one idle cycle between handshakes.
    for (int i = 0; i < 12; i++)
      do_read(0, 32'h0000_0100 + 32'(4 * i), 3, 1'b0, $sformatf("b2b%0d", i));

    // Counter saturation, starting just below the limit.
    @(negedge clk);
    force dut0.rd_count_reg = 16'hFFFE;
    @(negedge clk);
    release dut0.rd_count_reg;
    exp_cnt[0] = 32'hFFFE;
    sel = 0; #1;
    check("sat_preload", 32'(m_cnt), 32'hFFFE);
    do_read(0, 32'h0000_0200, 3, 1'b0, "sat_reach");
    do_read(0, 32'h0000_0204, 3, 1'b0, "sat_hold");

    // Latency-4 instance.
    do_read(1, 32'h0000_0002, 1, 1'b1, "lat4_misaligned");
    do_read(1, 32'h0000_0000, 6, 1'b0, "lat4_w0");

    // Reset while the latency-4 instance is waiting on the BRAM.
    sel = 1;
    @(negedge clk);
    req_addr = 32'h0000_0040; start1 = 1'b1;
    @(posedge clk); @(posedge clk); @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("rst_mid_wait");
    sel = 0; #1;
    check("rst_count0", 32'(m_cnt), 32'd0);
    exp_cnt[0] = 0; exp_cnt[1] = 0;
    sel = 1;
    @(negedge clk); start1 = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_no_stale", 32'(m_comp), 32'd0);
    do_read(1, 32'h0000_0020, 6, 1'b0, "post_reset_w8");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
